// File: rtl/irq_exc_pkg.sv
// Shared types and helpers for the interrupt/exception controller: FSM state
// encoding, cause-width helper and the fixed-priority encoder.
package irq_exc_pkg;

  localparam int unsigned MAX_IRQ     = 32;
  localparam int unsigned MAX_CAUSE_W = $clog2(MAX_IRQ);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RET     = 2'd3
  } state_e;

  function automatic int unsigned cause_width(input int unsigned num_irq);
    return $clog2(num_irq);
  endfunction

  // Channel 0 wins: scanning downwards leaves the lowest set index in idx.
  function automatic logic [MAX_CAUSE_W-1:0] lowest_set(input logic [MAX_IRQ-1:0] vec);
    logic [MAX_CAUSE_W-1:0] idx;
    idx = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = MAX_CAUSE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous request lines.
module irq_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs from before the edge, giving a true 2-flop chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/irq_exc_ctrl.sv
// Maskable, prioritised interrupt controller with EPC/cause capture and ERET.
// Define IRQ_EDGE_EN for sticky rising-edge pending; default is level mode.
module irq_exc_ctrl
  import irq_exc_pkg::*;
#(
  parameter int unsigned               NUM_IRQ    = 8,
  parameter int unsigned               PC_W       = 32,
  parameter logic [PC_W-1:0]           VEC_BASE   = 'h0000_0100,
  parameter int unsigned               VEC_STRIDE = 16,
  parameter logic [NUM_IRQ-1:0]        MASK_RST   = '1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_IRQ-1:0]           irq_i,
  input  logic                         instr_valid_i,
  input  logic [PC_W-1:0]              pc_i,
  input  logic                         return_i,
  input  logic                         mask_we_i,
  input  logic [NUM_IRQ-1:0]           mask_wdata_i,
  output logic                         redirect_o,
  output logic [PC_W-1:0]              redirect_pc_o,
  output logic [PC_W-1:0]              epc_o,
  output logic [cause_width(NUM_IRQ)-1:0] cause_o,
  output logic                         in_handler_o,
  output logic [NUM_IRQ-1:0]           mask_o
);

  localparam int unsigned CAUSE_W = cause_width(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] enabled;
  logic [NUM_IRQ-1:0] mask_q;
  logic [CAUSE_W-1:0] winner;
  logic               take;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;

  irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (irq_i),
    .q_o    (irq_s)
  );

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_s_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;

  // Clear first, then OR in new edges so a coincident edge re-arms the channel.
  always_comb begin
    pending_d = pending_q;
    if (state_q == ST_TAKE) pending_d[cause_q] = 1'b0;
    pending_d = pending_d | (irq_s & ~irq_s_prev_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_s_prev_q <= '0;
      pending_q    <= '0;
    end else begin
      irq_s_prev_q <= irq_s;
      pending_q    <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  assign pending = irq_s;
`endif

  // The registered mask means a same-edge write only affects the next decision.
  assign enabled = pending & mask_q;
  assign winner  = CAUSE_W'(lowest_set(MAX_IRQ'(enabled)));
  assign take    = (state_q == ST_IDLE) && (|enabled) && instr_valid_i;

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_TAKE;
          epc_d   = pc_i;
          cause_d = winner;
        end
      end
      ST_TAKE:    state_d = ST_HANDLER;
      ST_HANDLER: if (return_i) state_d = ST_RET;
      ST_RET:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      mask_q  <= MASK_RST;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      if (mask_we_i) mask_q <= mask_wdata_i;
    end
  end

  // Outputs decode registered state only; nothing here depends on inputs.
  always_comb begin
    redirect_pc_o = '0;
    unique case (state_q)
      ST_TAKE: redirect_pc_o = VEC_BASE + PC_W'(cause_q) * PC_W'(VEC_STRIDE);
      ST_RET:  redirect_pc_o = epc_q;
      default: redirect_pc_o = '0;
    endcase
  end

  assign redirect_o   = (state_q == ST_TAKE) || (state_q == ST_RET);
  assign in_handler_o = (state_q != ST_IDLE);
  assign epc_o        = epc_q;
  assign cause_o      = cause_q;
  assign mask_o       = mask_q;

endmodule
